// File: rtl/fifo_param_top.sv
// Parametrised synchronous FIFO driven by a packed write/read/data command word.
// Provides occupancy count, threshold flags, sticky error flags and a synchronous flush.
module fifo_param_top #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned AF_THRESH = 3,
  parameter int unsigned AE_THRESH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W+1:0] vector_in,
  input  logic              flush,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W:0]   count,
  output logic              empty_flag,
  output logic              full_flag,
  output logic              almost_empty_flag,
  output logic              almost_full_flag,
  output logic              overflow_flag,
  output logic              underflow_flag
);

  localparam int unsigned    DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DepthCnt = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AfCnt    = AF_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] AeCnt    = AE_THRESH[ADDR_W:0];

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wp_q, rp_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] data_q;
  logic              ovf_q, unf_q;

  logic              wr_cmd, rd_cmd, wr_ok, rd_ok, is_empty, is_full;
  logic [DATA_W-1:0] wdata;

  always_comb begin
    wr_cmd   = vector_in[DATA_W+1];
    rd_cmd   = vector_in[DATA_W];
    wdata    = vector_in[DATA_W-1:0];
    is_empty = (count_q == '0);
    is_full  = (count_q == DepthCnt);
    rd_ok    = rd_cmd && !is_empty;
    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    wr_ok    = wr_cmd && (!is_full || rd_ok);
    count_d  = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + (ADDR_W+1)'(1);
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - (ADDR_W+1)'(1);
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok && !flush && !reset) begin
      mem_q[wp_q] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (flush) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_ok) begin
        wp_q <= wp_q + ADDR_W'(1);
      end
      if (rd_ok) begin
        data_q <= mem_q[rp_q];
        rp_q   <= rp_q + ADDR_W'(1);
      end
      if (wr_cmd && !wr_ok) begin
        ovf_q <= 1'b1;
      end
      if (rd_cmd && !rd_ok) begin
        unf_q <= 1'b1;
      end
      count_q <= count_d;
    end
  end

  assign data_out          = data_q;
  assign count             = count_q;
  assign empty_flag        = is_empty;
  assign full_flag         = is_full;
  assign almost_empty_flag = (count_q <= AeCnt);
  assign almost_full_flag  = (count_q >= AfCnt);
  assign overflow_flag     = ovf_q;
  assign underflow_flag    = unf_q;

endmodule

// File: tb/tb_fifo_param_top.sv
// Self-checking bench for fifo_param_top: directed scenarios then random commands,
// all compared against a queue-based reference model.
module tb_fifo_param_top;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] vector_in;
  logic       flush;
  logic [3:0] data_out;
  logic [2:0] count;
  logic       empty_flag, full_flag, almost_empty_flag, almost_full_flag;
  logic       overflow_flag, underflow_flag;

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  logic [3:0] q[$];
  logic [3:0] m_dout;
  bit         m_ovf, m_unf;

  fifo_param_top dut (
    .clk              (clk),
    .reset            (reset),
    .vector_in        (vector_in),
    .flush            (flush),
    .data_out         (data_out),
    .count            (count),
    .empty_flag       (empty_flag),
    .full_flag        (full_flag),
    .almost_empty_flag(almost_empty_flag),
    .almost_full_flag (almost_full_flag),
    .overflow_flag    (overflow_flag),
    .underflow_flag   (underflow_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = 4'h0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".data_out"}, 32'(data_out), 32'(m_dout));
    chk({tag, ".empty"}, 32'(empty_flag), 32'(n == 0));
    chk({tag, ".full"}, 32'(full_flag), 32'(n == 4));
    chk({tag, ".aempty"}, 32'(almost_empty_flag), 32'(n <= 1));
    chk({tag, ".afull"}, 32'(almost_full_flag), 32'(n >= 3));
    chk({tag, ".ovf"}, 32'(overflow_flag), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(underflow_flag), 32'(m_unf));
  endtask

  // Drive one command, clock it in, advance the model, then check everything.
  task automatic step(input bit w, input bit r, input logic [3:0] d, input bit f,
                      input string tag);
    bit rd_ok, wr_ok;
    vector_in = {w, r, d};
    flush     = f;
    @(posedge clk);
    if (f) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      rd_ok = r && (q.size() > 0);
      wr_ok = w && ((q.size() < 4) || rd_ok);
      if (rd_ok) m_dout = q.pop_front();
      if (r && !rd_ok) m_unf = 1'b1;
      if (w && !wr_ok) m_ovf = 1'b1;
      if (wr_ok) q.push_back(d);
    end
    #1;
    vector_in = 6'h0;
    flush     = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [3:0] seq1 [4] = '{4'hF, 4'hE, 4'hD, 4'h9};
    logic [3:0] seq2 [4] = '{4'h0, 4'h1, 4'h7, 4'h6};
    reset = 1'b1;
    vector_in = 6'h0;
    flush = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    reset = 1'b0;

    // Fill with F,E,D,9 then drain in order
    for (int i = 0; i < 4; i++) step(1, 0, seq1[i], 0, "fill");
    step(0, 0, 4'h0, 0, "idle");
    chk("full_after4", 32'(full_flag), 32'd1);
    chk("count_after4", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 4'h0, 0, "drain");
      chk("drain_data", 32'(data_out), 32'(seq1[i]));
    end
    chk("empty_after_drain", 32'(empty_flag), 32'd1);

    // Eight writes into four slots: overflow after the fifth
    for (int i = 0; i < 8; i++) begin
      step(1, 0, seq2[i % 4], 0, "overfill");
      if (i == 4) chk("ovf_on_5th", 32'(overflow_flag), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 4'h0, 0, "ovf_drain");
      chk("ovf_drain_data", 32'(data_out), 32'(seq2[i]));
    end

    // Underflow, then read+write on empty: write lands, read refused
    step(0, 1, 4'h0, 0, "rd_empty");
    chk("unf_set", 32'(underflow_flag), 32'd1);
    step(1, 1, 4'hA, 0, "rw_empty");
    chk("rw_empty_count", 32'(count), 32'd1);
    chk("rw_empty_dout", 32'(data_out), 32'h6);
    step(0, 1, 4'h0, 0, "rd_A");
    chk("rd_A_data", 32'(data_out), 32'hA);

    // Read+write on full keeps count and returns the old head
    step(0, 0, 4'h0, 1, "flush1");
    for (int i = 0; i < 4; i++) step(1, 0, 4'(5 + i), 0, "fill2");
    step(1, 1, 4'h3, 0, "rw_full");
    chk("rw_full_count", 32'(count), 32'd4);
    chk("rw_full_dout", 32'(data_out), 32'h5);
    chk("rw_full_ovf", 32'(overflow_flag), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 1, 4'h0, 0, "drain2");
    chk("wrap_last", 32'(data_out), 32'h3);

    // Flush with errors set and a write pending
    step(0, 1, 4'h0, 0, "unf2");
    for (int i = 0; i < 5; i++) step(1, 0, 4'(i), 0, "fill3");
    step(0, 1, 4'h0, 0, "to3");
    chk("pre_flush_count", 32'(count), 32'd3);
    step(1, 0, 4'hC, 1, "flush_w");
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_ovf", 32'(overflow_flag), 32'd0);
    chk("flush_unf", 32'(underflow_flag), 32'd0);

    // Async reset mid-burst: outputs clear before the next edge
    step(1, 0, 4'h4, 0, "burst");
    step(1, 0, 4'h5, 0, "burst");
    step(0, 1, 4'h0, 0, "burst");
    step(0, 1, 4'h0, 0, "burst");
    step(0, 1, 4'h0, 0, "burst");
    step(1, 0, 4'h8, 0, "burst");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    vector_in = 6'h3F;
    @(posedge clk);
    #1;
    check_all("reset_held");
    #2;
    reset = 1'b0;
    vector_in = 6'h0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] d;
      bit w, r, f;
      d = 4'($urandom);
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      f = ($urandom_range(0, 31) == 0);
      step(w, r, d, f, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fifo_param_top.md
# fifo_param_top

Parametrised synchronous FIFO, the successor to the fixed 4x4-bit command-vector FIFO. It keeps the packed command/data input word and adds configurable data width and depth, an occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a synchronous flush. It sits between a command-driven producer and a consumer in the same clock domain, as the general buffering element for queue and adder datapaths.

## Interface
- DATA_W, 4: data word width in bits.
- ADDR_W, 2: pointer width; DEPTH = 2**ADDR_W entries (default 4).
- AF_THRESH, 3: almost_full_flag asserts when count >= AF_THRESH (range 1..DEPTH).
- AE_THRESH, 1: almost_empty_flag asserts when count <= AE_THRESH (range 0..DEPTH-1).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- vector_in  in  DATA_W+2  packed command: [DATA_W+1] = write, [DATA_W] = read, [DATA_W-1:0] = write data.
- flush  in  1  synchronous clear of contents and error flags.
- data_out  out  DATA_W  registered read data; holds its value between reads.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- empty_flag  out  1  count == 0.
- full_flag  out  1  count == DEPTH.
- almost_empty_flag  out  1  count <= AE_THRESH.
- almost_full_flag  out  1  count >= AF_THRESH.
- overflow_flag  out  1  sticky; a write was refused because the FIFO was full.
- underflow_flag  out  1  sticky; a read was refused because the FIFO was empty.

## Operation
- Storage: DEPTH x DATA_W register array. Write pointer wp and read pointer rp are ADDR_W bits wide and wrap modulo DEPTH. count is a separate ADDR_W+1-bit register.
- Command decode per edge, from write (w) and read (r) bits: 00 idle; 10 write; 01 read; 11 read and write.
- Write accepted if not full, or if full with an accepted read in the same cycle. Accepted write: mem[wp] <= data, wp <= wp+1.
- Read accepted if not empty. Accepted read: data_out <= mem[rp], rp <= rp+1.
- Read and write with count in 1..DEPTH: both accepted, count unchanged, and data_out takes the old head.
- Read and write when empty: write accepted, read refused, underflow_flag set, data_out unchanged. There is no bypass.
- Refused write (full, no read): data discarded, overflow_flag set, and nothing else changes.
- Refused read (empty): underflow_flag set; data_out, rp and count unchanged.
- count updates by +1 (write only), -1 (read only) or 0.
- flush = 1: wp, rp and count are set to 0, and overflow_flag and underflow_flag are cleared. Any command in that cycle is ignored. data_out and memory contents are unchanged. flush takes priority over vector_in.
- All flags are decoded combinationally from registered count, except the two error flags, which are registers.
- Reset values: data_out = 0, count = 0, wp = rp = 0, empty_flag = 1, full_flag = 0, almost_empty_flag = 1 (when AE_THRESH >= 0), almost_full_flag = 0, overflow_flag = 0, underflow_flag = 0. Memory contents are not reset.

## Timing
- vector_in and flush are sampled at the rising edge of clk.
- Write latency: data is readable by a read command sampled on the following edge.
- Read latency: data_out is valid immediately after the edge that samples the read, i.e. one cycle of registered latency.
- count, empty_flag, full_flag and the almost flags reflect the command sampled at edge N from just after edge N.
- Error flags set at the edge that samples the offending command and stay set until reset or flush.
- Reset asserted mid-operation: all outputs go to their reset values without waiting for a clock edge. Commands are ignored while reset is high. The first command is sampled at the first rising edge after reset deasserts.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no gap. Full and empty are never inferred from pointer equality alone.

## Test plan
All scenarios use default parameters.
- Reset, then 4 writes 0xF, 0xE, 0xD, 0x9, then idle -> count = 4, full_flag = 1, almost_full_flag = 1, empty_flag = 0, no error flags.
- Then 4 reads -> data_out = F, E, D, 9 on successive edges; count ends at 0 with empty_flag = 1; almost_empty_flag asserts once count = 1.
- 8 writes 0, 1, 7, 6, 0, 1, 7, 6 from empty -> count = 4 after the 4th write and overflow_flag = 1 after the 5th; subsequent reads return 0, 1, 7, 6.
- Read when empty, then read+write (11) with data 0xA when empty -> underflow_flag = 1, count = 1, data_out unchanged; the next read returns 0xA.
- Full FIFO, read+write with data 0x3 -> count stays 4, data_out = old head, overflow_flag stays 0; after draining, 0x3 is the last word out. Confirms wrap-around.
- Fill 3 entries with the error flags set, then flush together with a write command -> count = 0, empty_flag = 1, error flags = 0, write ignored. Separately, async reset mid-burst -> all outputs return to reset values before the next edge.
